// File: rtl/taylor_pkg.sv
// Shared definitions for the Taylor cosine sweep driver: word format and FSM encoding.
package taylor_pkg;
  localparam int W         = 24;
  localparam int FXP_SHIFT = 10;
  localparam logic [W-1:0] FXP_ONE = {{(W-FXP_SHIFT-1){1'b0}}, 1'b1, {FXP_SHIFT{1'b0}}};

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CAPTURE, FINISH} drv_state_t;
endpackage

// File: rtl/taylor_result_buf.sv
// Result buffer: one write port, one registered read port. Contents survive reset.
module taylor_result_buf
  import taylor_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] wa_i,
  input  logic [W-1:0]  wd_i,
  input  logic [AW-1:0] ra_i,
  output logic [W-1:0]  rd_o
);
  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] rd_q;

  // Read samples the pre-write word, so a same-cycle write to ra_i returns old data.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[wa_i] <= wd_i;
    rd_q <= mem_q[ra_i];
  end

  assign rd_o = rd_q;
endmodule

// File: rtl/taylor_sweep_driver.sv
// Sweeps a range of angles through the Taylor cosine engine one at a time and
// buffers each result for later readback.
module taylor_sweep_driver
  import taylor_pkg::*;
#(
  parameter  int DEPTH   = 16,
  parameter  int TIMEOUT = 64,
  localparam int CW      = $clog2(DEPTH+1),
  localparam int AW      = $clog2(DEPTH),
  localparam int TW      = $clog2(TIMEOUT+1)
) (
  input  logic          clock_i,
  input  logic          reset_i,
  input  logic          run_i,
  input  logic [W-1:0]  angle_base_i,
  input  logic [W-1:0]  angle_step_i,
  input  logic [CW-1:0] sample_count_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          error_o,
  output logic [CW-1:0] wr_count_o,
  output logic          eng_start_o,
  output logic [W-1:0]  eng_angle_o,
  input  logic          eng_ready_i,
  input  logic [W-1:0]  eng_result_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [W-1:0]  rd_data_o
);
  drv_state_t    state_q, state_d;
  logic [CW-1:0] count_q, count_d, wr_count_q, wr_count_d, count_in, wr_next;
  logic [W-1:0]  angle_q, angle_d, step_q, step_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          error_q, error_d, buf_we, rd_vld_q;
  logic [W-1:0]  buf_rd;

  assign count_in = (sample_count_i > CW'(DEPTH)) ? CW'(DEPTH) : sample_count_i;
  assign wr_next  = wr_count_q + CW'(1);

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    wr_count_d = wr_count_q;
    angle_d    = angle_q;
    step_d     = step_q;
    tmo_d      = tmo_q;
    error_d    = error_q;
    buf_we     = 1'b0;
    case (state_q)
      IDLE: if (run_i) begin
        count_d    = count_in;
        step_d     = angle_step_i;
        angle_d    = angle_base_i;
        wr_count_d = '0;
        error_d    = 1'b0;
        tmo_d      = '0;
        state_d    = (count_in == '0) ? FINISH : ISSUE;
      end
      ISSUE: begin
        tmo_d = tmo_q + TW'(1);
        if (tmo_q == TW'(TIMEOUT-1)) begin
          error_d = 1'b1;
          state_d = FINISH;
        end else if (!eng_ready_i) state_d = WAIT;
      end
      WAIT: begin
        tmo_d = tmo_q + TW'(1);
        // A result arriving on the last allowed cycle still wins over the abort.
        if (eng_ready_i) state_d = CAPTURE;
        else if (tmo_q == TW'(TIMEOUT-1)) begin
          error_d = 1'b1;
          state_d = FINISH;
        end
      end
      CAPTURE: begin
        buf_we     = 1'b1;
        wr_count_d = wr_next;
        angle_d    = angle_q + step_q;
        tmo_d      = '0;
        state_d    = (wr_next == count_q) ? FINISH : ISSUE;
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      count_q    <= '0;
      wr_count_q <= '0;
      angle_q    <= '0;
      step_q     <= '0;
      tmo_q      <= '0;
      error_q    <= 1'b0;
      rd_vld_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      wr_count_q <= wr_count_d;
      angle_q    <= angle_d;
      step_q     <= step_d;
      tmo_q      <= tmo_d;
      error_q    <= error_d;
      rd_vld_q   <= 1'b1;
    end
  end

  taylor_result_buf #(.DEPTH(DEPTH)) u_buf (
    .clk_i (clock_i),
    .we_i  (buf_we),
    .wa_i  (wr_count_q[AW-1:0]),
    .wd_i  (eng_result_i),
    .ra_i  (rd_addr_i),
    .rd_o  (buf_rd)
  );

  assign busy_o      = (state_q == ISSUE) || (state_q == WAIT) || (state_q == CAPTURE);
  assign done_o      = (state_q == FINISH);
  assign error_o     = error_q;
  assign wr_count_o  = wr_count_q;
  // Reset gates start combinationally so the engine sees it drop in the reset cycle.
  assign eng_start_o = ((state_q == ISSUE) || (state_q == WAIT)) && !reset_i;
  assign eng_angle_o = angle_q;
  assign rd_data_o   = rd_vld_q ? buf_rd : '0;
endmodule
